vec_mem_bus_arbiter: RTL and testbench

//  Shares one VecMemoryBus port between NUM_REQ requesters: 0=fetch, 1=operand fetch, 2=store.

---
 rtl/vec_mem_bus_arbiter_pkg.sv | 18 +
 rtl/vec_mem_bus_arbiter_tag_fifo.sv | 51 +++++
 rtl/vec_mem_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_vec_mem_bus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_bus_arbiter_pkg.sv
// Shared types and constants for the vector memory bus arbiter.
package vec_mem_bus_arbiter_pkg;

  // Requester slots on the shared bus port
  localparam int REQ_FETCH   = 0;
  localparam int REQ_OPERAND = 1;
  localparam int REQ_STORE   = 2;

  // Bus ID width carried in each outstanding-read tag
  localparam int ARB_ID_W = 16;

  // One outstanding read: which requester issued it and the ID it was issued with
  typedef struct packed {
    logic [2:0]          idx;
    logic [ARB_ID_W-1:0] id;
  } arb_tag_t;

endpackage

// File: rtl/vec_mem_bus_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers who issued each outstanding read.
module arb_tag_fifo
  import vec_mem_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Tag storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vec_mem_bus_arbiter.sv
// Round-robin arbiter sharing one vector memory bus port among NUM_REQ requesters.
module vec_mem_bus_arbiter
  import vec_mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 256,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_is_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_is_write,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_wdata,
  output logic [ID_W-1:0]           mem_req_id,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  input  logic [ID_W-1:0]           mem_rsp_id,
  output logic                      mem_rsp_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      stall_pulse,
  output logic                      err_id_mismatch
);

  localparam int RR_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [RR_W-1:0]    rr_ptr;
  logic [RR_W-1:0]    winner;
  logic [NUM_REQ-1:0] cand;
  logic               out_free;
  logic               grant;
  logic               push;
  logic               pop;
  logic               tag_full;
  logic               tag_empty;
  logic [CNT_W-1:0]   tag_count;
  arb_tag_t           tag_in;
  arb_tag_t           tag_head;

  // Round-robin pick among eligible requesters; reads wait while the tag FIFO is full
  always_comb begin
    cand     = '0;
    winner   = '0;
    grant    = 1'b0;
    out_free = !mem_req_valid || mem_req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = req_valid[i] && (req_is_write[i] || !tag_full);
    end
    // Scan from farthest to nearest so the first candidate at or after rr_ptr wins
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand[(int'(rr_ptr) + k) % NUM_REQ]) begin
        winner = RR_W'((int'(rr_ptr) + k) % NUM_REQ);
        grant  = 1'b1;
      end
    end
    grant     = grant && out_free && !reset;
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
    stall_pulse = (|req_valid) && !grant && !reset;
  end

  assign push       = grant && !req_is_write[winner];
  assign tag_in.idx = 3'(winner);
  assign tag_in.id  = req_id[int'(winner)*ID_W +: ID_W];

  // Route the in-order response to the requester recorded at the FIFO head
  always_comb begin
    rsp_valid     = '0;
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!tag_empty && !reset && (tag_head.idx == 3'(i))) begin
        rsp_valid[i]  = mem_rsp_valid;
        mem_rsp_ready = rsp_ready[i];
      end
    end
  end

  assign pop      = mem_rsp_valid && mem_rsp_ready;
  assign rsp_data = mem_rsp_data;

  // Output request register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr           <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_is_write <= 1'b0;
      mem_req_addr     <= '0;
      mem_req_wdata    <= '0;
      mem_req_id       <= '0;
    end else if (grant) begin
      rr_ptr           <= (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      mem_req_valid    <= 1'b1;
      mem_req_is_write <= req_is_write[winner];
      mem_req_addr     <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
      mem_req_wdata    <= req_wdata[int'(winner)*DATA_W +: DATA_W];
      mem_req_id       <= req_id[int'(winner)*ID_W +: ID_W];
    end else if (mem_req_ready) begin
      mem_req_valid    <= 1'b0;
    end
  end

  // Sticky error: unexpected response or response ID not matching the issued one
  always_ff @(posedge clk) begin
    if (reset) begin
      err_id_mismatch <= 1'b0;
    end else if (mem_rsp_valid && tag_empty) begin
      err_id_mismatch <= 1'b1;
    end else if (pop && (mem_rsp_id != tag_head.id)) begin
      err_id_mismatch <= 1'b1;
    end
  end

  // Occupancy can never exceed the number of tag slots
  always_ff @(posedge clk) begin
    if (!reset) assert (tag_count <= CNT_W'(TAG_DEPTH));
  end

  arb_tag_fifo #(
    .WIDTH ($bits(arb_tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (tag_in),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

endmodule

// File: tb/tb_vec_mem_bus_arbiter.sv
// Testbench for vec_mem_bus_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_vec_mem_bus_arbiter;

  localparam int NR = 3;
  localparam int AW = 256;
  localparam int DW = 256;
  localparam int IW = 16;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]    req_valid, req_is_write, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*IW-1:0] req_id;
  logic             mem_req_valid, mem_req_ready, mem_req_is_write;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_wdata;
  logic [IW-1:0]    mem_req_id;
  logic             mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]    mem_rsp_data, rsp_data;
  logic [IW-1:0]    mem_rsp_id;
  logic             stall_pulse, err_id_mismatch;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_rr;
  bit          m_ov, m_ow, m_err;
  logic [AW-1:0] m_oa;
  logic [DW-1:0] m_od;
  logic [IW-1:0] m_oi;
  int          m_qidx[$];
  logic [IW-1:0] m_qid[$];
  int          e_win;
  logic [NR-1:0] e_req_ready, e_rsp_valid;
  logic        e_stall, e_mrr;
  logic [IW-1:0] mem_q[$];

  always #5 clk = ~clk;

  vec_mem_bus_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_is_write(req_is_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_id(req_id), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_is_write(mem_req_is_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_id(mem_req_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_id(mem_rsp_id),
    .mem_rsp_ready(mem_rsp_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .stall_pulse(stall_pulse), .err_id_mismatch(err_id_mismatch)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_is_write = '0; req_addr = '0; req_wdata = '0; req_id = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_id = '0;
    rsp_ready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expected combinational outputs from model state and current inputs
  function automatic void model_comb();
    int i;
    e_win = -1; e_req_ready = '0; e_rsp_valid = '0; e_mrr = 1'b0; e_stall = 1'b0;
    if (reset) return;
    if (!m_ov || mem_req_ready) begin
      for (int k = 0; k < NR; k++) begin
        i = (m_rr + k) % NR;
        if (e_win < 0 && req_valid[i] && (req_is_write[i] || m_qidx.size() < TD)) e_win = i;
      end
    end
    if (e_win >= 0) e_req_ready[e_win] = 1'b1;
    e_stall = (req_valid != '0) && (e_win < 0);
    if (m_qidx.size() > 0) begin
      e_rsp_valid[m_qidx[0]] = mem_rsp_valid;
      e_mrr = rsp_ready[m_qidx[0]];
    end
  endfunction

  // Advance the model across one clock edge
  function automatic void model_seq();
    if (reset) begin
      m_rr = 0; m_ov = 0; m_ow = 0; m_oa = '0; m_od = '0; m_oi = '0; m_err = 0;
      m_qidx.delete(); m_qid.delete();
      return;
    end
    if (mem_rsp_valid && m_qidx.size() == 0) m_err = 1;
    else if (mem_rsp_valid && e_mrr) begin
      if (mem_rsp_id != m_qid[0]) m_err = 1;
      void'(m_qidx.pop_front());
      void'(m_qid.pop_front());
    end
    if (m_ov && mem_req_ready) m_ov = 0;
    if (e_win >= 0) begin
      m_ov = 1;
      m_ow = req_is_write[e_win];
      m_oa = req_addr[e_win*AW +: AW];
      m_od = req_wdata[e_win*DW +: DW];
      m_oi = req_id[e_win*IW +: IW];
      if (!m_ow) begin
        m_qidx.push_back(e_win);
        m_qid.push_back(m_oi);
      end
      m_rr = (e_win + 1) % NR;
    end
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req_valid = 3'b111; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; rsp_ready = 3'b111;
    #1;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_req_ready got %b want 000", req_ready); else n_pass++;
    n_checks++; if (stall_pulse !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_pulse); else n_pass++;
    n_checks++; if (rsp_valid !== 3'b000 || mem_rsp_ready !== 1'b0) $display("FAIL reset_rsp got %b/%b want 000/0", rsp_valid, mem_rsp_ready); else n_pass++;
    tick();
    tick();
    n_checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_id !== '0) $display("FAIL reset_mem_req got v=%b id=%h want v=0 id=0", mem_req_valid, mem_req_id); else n_pass++;
    n_checks++; if (err_id_mismatch !== 1'b0) $display("FAIL reset_err got %b want 0", err_id_mismatch); else n_pass++;
    reset = 1'b0;
    idle_inputs();
    tick();
    n_checks++; if (err_id_mismatch !== 1'b0 || mem_req_valid !== 1'b0) $display("FAIL reset_release got err=%b v=%b want 0/0", err_id_mismatch, mem_req_valid); else n_pass++;
  endtask

  task automatic test_rr_order();
    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    mem_req_ready = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < NR; i++) begin
      req_id[i*IW +: IW] = IW'(16'h0100 + i);
      req_addr[i*AW +: AW] = {8{32'hA000_0000 + 32'(i)}};
    end
    for (int g = 0; g < 4; g++) begin
      #1;
      n_checks++; if (req_ready !== exp_g[g]) $display("FAIL rr_grant%0d got %b want %b", g, req_ready, exp_g[g]); else n_pass++;
      n_checks++; if (mem_req_valid !== (g > 0)) $display("FAIL rr_latency%0d got %b want %b", g, mem_req_valid, (g > 0)); else n_pass++;
      if (g > 0) begin
        n_checks++; if (mem_req_id !== IW'(16'h0100 + (g - 1) % NR)) $display("FAIL rr_id%0d got %h want %h", g, mem_req_id, 16'h0100 + (g - 1) % NR); else n_pass++;
      end
      tick();
    end
    #1;
    n_checks++; if (req_ready !== 3'b000 || stall_pulse !== 1'b1) $display("FAIL rr_full_block got %b/%b want 000/1", req_ready, stall_pulse); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 3'b001;
    req_id[0 +: IW] = 16'h0A0A;
    req_addr[0 +: AW] = {8{32'h1111_2222}};
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL bp_first_grant got %b want 001", req_ready); else n_pass++;
    tick();
    req_id[0 +: IW] = 16'h0B0B;
    req_addr[0 +: AW] = {8{32'h3333_4444}};
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_ready !== 3'b000 || stall_pulse !== 1'b1) $display("FAIL bp_stall%0d got %b/%b want 000/1", c, req_ready, stall_pulse); else n_pass++;
      n_checks++; if (mem_req_valid !== 1'b1 || mem_req_id !== 16'h0A0A || mem_req_addr !== {8{32'h1111_2222}}) $display("FAIL bp_hold%0d got v=%b id=%h want v=1 id=0a0a", c, mem_req_valid, mem_req_id); else n_pass++;
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL bp_release got %b want 001", req_ready); else n_pass++;
    tick();
    #1;
    n_checks++; if (mem_req_id !== 16'h0B0B) $display("FAIL bp_next_id got %h want 0b0b", mem_req_id); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] d;
    do_reset();
    mem_req_ready = 1'b1;
    req_valid = 3'b010;
    for (int k = 0; k < TD; k++) begin
      req_id[1*IW +: IW] = IW'(16'h0300 + k);
      #1;
      n_checks++; if (req_ready !== 3'b010) $display("FAIL ff_read%0d got %b want 010", k, req_ready); else n_pass++;
      tick();
    end
    req_valid = 3'b110; req_is_write = 3'b100;
    req_wdata[2*DW +: DW] = {8{32'hDEAD_BEEF}};
    req_id[2*IW +: IW] = 16'h0777;
    #1;
    n_checks++; if (req_ready !== 3'b100) $display("FAIL ff_write_grant got %b want 100", req_ready); else n_pass++;
    tick();
    req_valid = 3'b010;
    #1;
    n_checks++; if (req_ready !== 3'b000 || stall_pulse !== 1'b1) $display("FAIL ff_read_blocked got %b/%b want 000/1", req_ready, stall_pulse); else n_pass++;
    n_checks++; if (mem_req_is_write !== 1'b1 || mem_req_wdata !== {8{32'hDEAD_BEEF}} || mem_req_id !== 16'h0777) $display("FAIL ff_write_out got w=%b id=%h want w=1 id=0777", mem_req_is_write, mem_req_id); else n_pass++;
    tick();
    req_valid = '0; req_is_write = '0;
    mem_rsp_valid = 1'b1; rsp_ready = 3'b111;
    for (int k = 0; k < TD; k++) begin
      d = {8{$urandom()}};
      mem_rsp_data = d;
      mem_rsp_id = IW'(16'h0300 + k);
      #1;
      n_checks++; if (rsp_valid !== 3'b010 || rsp_data !== d) $display("FAIL ff_drain%0d got %b want 010", k, rsp_valid); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (rsp_valid !== 3'b000 || mem_rsp_ready !== 1'b0) $display("FAIL ff_no_write_tag got %b/%b want 000/0", rsp_valid, mem_rsp_ready); else n_pass++;
    n_checks++; if (err_id_mismatch !== 1'b0) $display("FAIL ff_err_clean got %b want 0", err_id_mismatch); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_routing();
    do_reset();
    mem_req_ready = 1'b1;
    req_valid = 3'b001; req_id[0 +: IW] = 16'h00A0;
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL rt_grant0 got %b want 001", req_ready); else n_pass++;
    tick();
    req_valid = 3'b100; req_id[2*IW +: IW] = 16'h00B0;
    #1;
    n_checks++; if (req_ready !== 3'b100) $display("FAIL rt_grant2 got %b want 100", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    mem_rsp_valid = 1'b1; mem_rsp_data = {32{8'hAA}}; mem_rsp_id = 16'h00A0; rsp_ready = 3'b111;
    #1;
    n_checks++; if (rsp_valid !== 3'b001 || rsp_data !== {32{8'hAA}} || mem_rsp_ready !== 1'b1) $display("FAIL rt_rsp0 got %b/%b want 001/1", rsp_valid, mem_rsp_ready); else n_pass++;
    tick();
    mem_rsp_data = {32{8'hBB}}; mem_rsp_id = 16'h00B0; rsp_ready = 3'b011;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (rsp_valid !== 3'b100 || mem_rsp_ready !== 1'b0) $display("FAIL rt_hold%0d got %b/%b want 100/0", c, rsp_valid, mem_rsp_ready); else n_pass++;
      tick();
    end
    rsp_ready = 3'b111;
    #1;
    n_checks++; if (rsp_valid !== 3'b100 || rsp_data !== {32{8'hBB}} || mem_rsp_ready !== 1'b1) $display("FAIL rt_rsp2 got %b/%b want 100/1", rsp_valid, mem_rsp_ready); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_checks++; if (err_id_mismatch !== 1'b0 || rsp_valid !== 3'b000) $display("FAIL rt_done got err=%b rv=%b want 0/000", err_id_mismatch, rsp_valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_id_mismatch();
    do_reset();
    mem_req_ready = 1'b1;
    req_valid = 3'b010; req_id[1*IW +: IW] = 16'h0101;
    tick();
    req_valid = '0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = {32{8'hCC}}; mem_rsp_id = 16'h0102; rsp_ready = 3'b111;
    #1;
    n_checks++; if (rsp_valid !== 3'b010 || rsp_data !== {32{8'hCC}} || err_id_mismatch !== 1'b0) $display("FAIL idm_route got %b err=%b want 010 err=0", rsp_valid, err_id_mismatch); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (err_id_mismatch !== 1'b1) $display("FAIL idm_sticky%0d got %b want 1", c, err_id_mismatch); else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req_ready = 1'b1;
    req_valid = 3'b011;
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL rm_grant0 got %b want 001", req_ready); else n_pass++;
    tick();
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL rm_grant1 got %b want 010", req_ready); else n_pass++;
    tick();
    req_valid = '0; mem_req_ready = 1'b0;
    #1;
    n_checks++; if (mem_req_valid !== 1'b1) $display("FAIL rm_pending got %b want 1", mem_req_valid); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (mem_req_valid !== 1'b0 || mem_req_id !== '0 || err_id_mismatch !== 1'b0) $display("FAIL rm_cleared got v=%b id=%h err=%b want 0/0000/0", mem_req_valid, mem_req_id, err_id_mismatch); else n_pass++;
    mem_rsp_valid = 1'b1; mem_rsp_id = 16'h0100; rsp_ready = 3'b111;
    #1;
    n_checks++; if (rsp_valid !== 3'b000 || mem_rsp_ready !== 1'b0) $display("FAIL rm_stray got %b/%b want 000/0", rsp_valid, mem_rsp_ready); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_checks++; if (err_id_mismatch !== 1'b1) $display("FAIL rm_stray_err got %b want 1", err_id_mismatch); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    model_seq();
    reset = 1'b1; model_seq(); reset = 1'b0;
    mem_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = NR'($urandom());
      req_is_write = NR'($urandom());
      for (int i = 0; i < NR; i++) begin
        req_addr[i*AW +: AW] = {8{$urandom()}};
        req_wdata[i*DW +: DW] = {8{$urandom()}};
        req_id[i*IW +: IW] = IW'($urandom());
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = NR'($urandom());
      mem_rsp_data = {8{$urandom()}};
      if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_id = mem_q[0] ^ (($urandom_range(0, 79) == 0) ? 16'h0001 : 16'h0000);
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_id = '0;
      end
      #1;
      model_comb();
      n_checks++; if (req_ready !== e_req_ready) $display("FAIL rnd_req_ready c%0d got %b want %b", cyc, req_ready, e_req_ready); else n_pass++;
      n_checks++; if (stall_pulse !== e_stall) $display("FAIL rnd_stall c%0d got %b want %b", cyc, stall_pulse, e_stall); else n_pass++;
      n_checks++; if (rsp_valid !== e_rsp_valid || mem_rsp_ready !== e_mrr) $display("FAIL rnd_rsp c%0d got %b/%b want %b/%b", cyc, rsp_valid, mem_rsp_ready, e_rsp_valid, e_mrr); else n_pass++;
      n_checks++; if (rsp_data !== mem_rsp_data) $display("FAIL rnd_rsp_data c%0d got %h want %h", cyc, rsp_data[31:0], mem_rsp_data[31:0]); else n_pass++;
      n_checks++; if (mem_req_valid !== m_ov) $display("FAIL rnd_mem_valid c%0d got %b want %b", cyc, mem_req_valid, m_ov); else n_pass++;
      if (m_ov) begin
        n_checks++; if (mem_req_is_write !== m_ow || mem_req_addr !== m_oa || mem_req_wdata !== m_od || mem_req_id !== m_oi) $display("FAIL rnd_mem_payload c%0d got w=%b id=%h want w=%b id=%h", cyc, mem_req_is_write, mem_req_id, m_ow, m_oi); else n_pass++;
      end
      n_checks++; if (err_id_mismatch !== m_err) $display("FAIL rnd_err c%0d got %b want %b", cyc, err_id_mismatch, m_err); else n_pass++;
      model_seq();
      if (mem_rsp_valid && mem_rsp_ready && mem_q.size() > 0) void'(mem_q.pop_front());
      if (mem_req_valid && mem_req_ready && !mem_req_is_write) mem_q.push_back(mem_req_id);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_rr_order();
    test_backpressure();
    test_fifo_full();
    test_routing();
    test_id_mismatch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
